// File: rtl/avalon_st_packet_demux.sv
// Avalon-ST packet demultiplexer: broadcasts or routes whole packets by channel
// into per-port show-ahead FIFOs. Packets with an illegal channel are dropped and counted.
module avalon_st_packet_demux #(
   parameter int unsigned DATA_WIDTH    = 38,
   parameter int unsigned NUM_OUTPUTS   = 2,
   parameter int unsigned CHANNEL_WIDTH = 3,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                              clock_clk,
   input  logic                              reset_reset,
   input  logic                              cfg_broadcast,
   input  logic [DATA_WIDTH-1:0]             asi_in0_data,
   input  logic [CHANNEL_WIDTH-1:0]          asi_in0_channel,
   input  logic                              asi_in0_valid,
   output logic                              asi_in0_ready,
   input  logic                              asi_in0_startofpacket,
   input  logic                              asi_in0_endofpacket,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] aso_out_data,
   output logic [NUM_OUTPUTS-1:0]            aso_out_valid,
   input  logic [NUM_OUTPUTS-1:0]            aso_out_ready,
   output logic [NUM_OUTPUTS-1:0]            aso_out_startofpacket,
   output logic [NUM_OUTPUTS-1:0]            aso_out_endofpacket,
   output logic [15:0]                       drop_count
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned EW = DATA_WIDTH + 2;
   localparam logic [CHANNEL_WIDTH:0] NUM_OUT_C = NUM_OUTPUTS[CHANNEL_WIDTH:0];

   typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

   state_t                 state;
   logic [NUM_OUTPUTS-1:0] mask;
   logic [NUM_OUTPUTS-1:0] sop_mask;
   logic [NUM_OUTPUTS-1:0] write_mask;
   logic [NUM_OUTPUTS-1:0] full;
   logic [NUM_OUTPUTS-1:0] empty;
   logic [NUM_OUTPUTS-1:0] push;
   logic [NUM_OUTPUTS-1:0] pop;
   logic                   sop_legal;
   logic                   accept;
   logic [EW-1:0]          in_entry;

   assign in_entry = {asi_in0_startofpacket, asi_in0_endofpacket, asi_in0_data};

   always_comb begin
      sop_mask  = '0;
      sop_legal = 1'b0;
      if (cfg_broadcast) begin
         sop_mask  = '1;
         sop_legal = 1'b1;
      end else if ({1'b0, asi_in0_channel} < NUM_OUT_C) begin
         sop_legal = 1'b1;
         for (int unsigned k = 0; k < NUM_OUTPUTS; k++)
            sop_mask[k] = (asi_in0_channel == k[CHANNEL_WIDTH-1:0]);
      end
   end

   always_comb begin
      asi_in0_ready = 1'b1;
      case (state)
         IDLE:    asi_in0_ready = ~|full;
         PKT:     asi_in0_ready = ~|(full & mask);
         default: asi_in0_ready = 1'b1;
      endcase
   end

   assign accept = asi_in0_valid & asi_in0_ready;
   assign pop    = aso_out_valid & aso_out_ready;

   always_comb begin
      write_mask = '0;
      if (asi_in0_startofpacket)
         write_mask = sop_legal ? sop_mask : '0;
      else if (state == PKT)
         write_mask = mask;
   end

   // A mid-packet SOP can retarget to a FIFO that ready did not account for;
   // never overwrite a full FIFO unless it is popping in the same cycle.
   assign push = {NUM_OUTPUTS{accept}} & write_mask & (~full | pop);

   always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
         state      <= IDLE;
         mask       <= '0;
         drop_count <= '0;
      end else if (accept) begin
         if (asi_in0_startofpacket) begin
            if (sop_legal) begin
               mask  <= sop_mask;
               state <= asi_in0_endofpacket ? IDLE : PKT;
            end else begin
               if (drop_count != 16'hFFFF)
                  drop_count <= drop_count + 16'd1;
               state <= asi_in0_endofpacket ? IDLE : DROP;
            end
         end else if (state != IDLE && asi_in0_endofpacket) begin
            state <= IDLE;
         end
      end
   end

   for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_port
      logic [EW-1:0] mem [FIFO_DEPTH];
      logic [AW-1:0] wp;
      logic [AW-1:0] rp;
      logic [AW:0]   cnt;
      logic [EW-1:0] head;

      always_ff @(posedge clock_clk) begin
         if (push[k])
            mem[wp] <= in_entry;
      end

      always_ff @(posedge clock_clk) begin
         if (reset_reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
         end else begin
            if (push[k])
               wp <= wp + 1'b1;
            if (pop[k])
               rp <= rp + 1'b1;
            case ({push[k], pop[k]})
               2'b10:   cnt <= cnt + 1'b1;
               2'b01:   cnt <= cnt - 1'b1;
               default: cnt <= cnt;
            endcase
         end
      end

      assign head     = mem[rp];
      assign full[k]  = (cnt == FIFO_DEPTH[AW:0]);
      assign empty[k] = (cnt == '0);

      assign aso_out_valid[k]                          = ~empty[k];
      assign aso_out_data[k*DATA_WIDTH +: DATA_WIDTH]  = head[DATA_WIDTH-1:0];
      assign aso_out_startofpacket[k]                  = head[EW-1];
      assign aso_out_endofpacket[k]                    = head[EW-2];
   end

endmodule
